// File: rtl/leaky_relu_h_cache.sv
// Leaky ReLU forward stage with an in-order H cache replayed for backprop.
// Optional sticky overflow/underflow flags: define LR_H_CACHE_ERR_EN.
module leaky_relu_h_cache #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                lr_valid_in,
    input  logic signed [15:0]  lr_data_in,
    input  logic signed [15:0]  lr_leak_factor_in,
    output logic                lr_valid_out,
    output logic signed [15:0]  lr_data_out,
    input  logic                lr_h_rd_en,
    input  logic                lr_h_flush,
    output logic                lr_d_H_valid_out,
    output logic signed [15:0]  lr_d_H_data_out,
    output logic [AW:0]         lr_h_count,
    output logic                lr_h_full,
    output logic                lr_h_empty
`ifdef LR_H_CACHE_ERR_EN
    ,
    output logic [1:0]          lr_h_err
`endif
);

    localparam logic [AW:0] FULL_CNT = DEPTH[AW:0];

    // Q8.8 multiply: full product, keep the middle 16 bits (truncating).
    function automatic logic signed [15:0] fxp_mul(
        input logic signed [15:0] a,
        input logic signed [15:0] b
    );
        logic signed [31:0] p;
        p = a * b;
        return p[23:8];
    endfunction

    logic signed [15:0] mem [DEPTH];
    logic [AW-1:0]      wp;
    logic [AW-1:0]      rp;
    logic [AW:0]        count;
    logic               full;
    logic               empty;
    logic               wr_ok;
    logic               rd_ok;
    logic signed [15:0] act;

    assign full  = (count == FULL_CNT);
    assign empty = (count == '0);
    assign wr_ok = lr_valid_in && !full && !lr_h_flush;
    assign rd_ok = lr_h_rd_en && !empty && !lr_h_flush;

    assign lr_h_count = count;
    assign lr_h_full  = full;
    assign lr_h_empty = empty;

    always_comb begin
        act = '0;
        if (lr_valid_in) begin
            if (!lr_data_in[15])
                act = lr_data_in;
            else
                act = fxp_mul(lr_data_in, lr_leak_factor_in);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_valid_out <= 1'b0;
            lr_data_out  <= '0;
        end else begin
            lr_valid_out <= lr_valid_in;
            lr_data_out  <= act;
        end
    end

    // Storage is deliberately left out of reset.
    always_ff @(posedge clk) begin
        if (wr_ok)
            mem[wp] <= lr_data_in;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wp               <= '0;
            rp               <= '0;
            count            <= '0;
            lr_d_H_valid_out <= 1'b0;
            lr_d_H_data_out  <= '0;
        end else if (lr_h_flush) begin
            wp               <= '0;
            rp               <= '0;
            count            <= '0;
            lr_d_H_valid_out <= 1'b0;
            lr_d_H_data_out  <= '0;
        end else begin
            if (wr_ok)
                wp <= wp + 1'b1;
            if (rd_ok) begin
                rp               <= rp + 1'b1;
                lr_d_H_valid_out <= 1'b1;
                lr_d_H_data_out  <= mem[rp];
            end else begin
                lr_d_H_valid_out <= 1'b0;
                lr_d_H_data_out  <= '0;
            end
            case ({wr_ok, rd_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

`ifdef LR_H_CACHE_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lr_h_err <= 2'b00;
        end else if (!lr_h_flush) begin
            if (lr_valid_in && full)
                lr_h_err[0] <= 1'b1;
            if (lr_h_rd_en && empty)
                lr_h_err[1] <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_leaky_relu_h_cache.sv
// Directed self-checking bench for leaky_relu_h_cache (DEPTH = 16).
module tb_leaky_relu_h_cache;

    logic               clk;
    logic               rst;
    logic               lr_valid_in;
    logic signed [15:0] lr_data_in;
    logic signed [15:0] lr_leak_factor_in;
    logic               lr_valid_out;
    logic signed [15:0] lr_data_out;
    logic               lr_h_rd_en;
    logic               lr_h_flush;
    logic               lr_d_H_valid_out;
    logic signed [15:0] lr_d_H_data_out;
    logic [4:0]         lr_h_count;
    logic               lr_h_full;
    logic               lr_h_empty;
`ifdef LR_H_CACHE_ERR_EN
    logic [1:0]         lr_h_err;
`endif

    int n_vec = 0;
    int n_err = 0;

    leaky_relu_h_cache #(.DEPTH(16)) dut (
        .clk               (clk),
        .rst               (rst),
        .lr_valid_in       (lr_valid_in),
        .lr_data_in        (lr_data_in),
        .lr_leak_factor_in (lr_leak_factor_in),
        .lr_valid_out      (lr_valid_out),
        .lr_data_out       (lr_data_out),
        .lr_h_rd_en        (lr_h_rd_en),
        .lr_h_flush        (lr_h_flush),
        .lr_d_H_valid_out  (lr_d_H_valid_out),
        .lr_d_H_data_out   (lr_d_H_data_out),
        .lr_h_count        (lr_h_count),
        .lr_h_full         (lr_h_full),
        .lr_h_empty        (lr_h_empty)
`ifdef LR_H_CACHE_ERR_EN
        ,
        .lr_h_err          (lr_h_err)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        lr_valid_in = 1'b0;
        lr_data_in  = '0;
        lr_h_rd_en  = 1'b0;
        lr_h_flush  = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        idle();
        lr_leak_factor_in = 16'h0080;
        tick();
        tick();
        n_vec++;
        if (lr_valid_out !== 1'b0 || lr_data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_fwd got v=%b d=%h want v=0 d=0000",
                     lr_valid_out, lr_data_out);
        end
        n_vec++;
        if (lr_d_H_valid_out !== 1'b0 || lr_d_H_data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL reset_replay got v=%b d=%h want v=0 d=0000",
                     lr_d_H_valid_out, lr_d_H_data_out);
        end
        n_vec++;
        if (lr_h_count !== 5'd0 || lr_h_empty !== 1'b1 || lr_h_full !== 1'b0) begin
            n_err++;
            $display("FAIL reset_flags got cnt=%0d e=%b f=%b want cnt=0 e=1 f=0",
                     lr_h_count, lr_h_empty, lr_h_full);
        end
`ifdef LR_H_CACHE_ERR_EN
        n_vec++;
        if (lr_h_err !== 2'b00) begin
            n_err++;
            $display("FAIL reset_err got %b want 00", lr_h_err);
        end
`endif
        rst = 1'b0;
        tick();
    endtask

    task automatic test_forward();
        logic [15:0] din [4];
        logic [15:0] dexp [4];
        logic        vin [4];
        din  = '{16'h0200, 16'hFE00, 16'h0000, 16'hFE00};
        dexp = '{16'h0200, 16'hFF00, 16'h0000, 16'h0000};
        vin  = '{1'b1, 1'b1, 1'b1, 1'b0};
        lr_leak_factor_in = 16'h0080;
        for (int i = 0; i < 4; i++) begin
            lr_valid_in = vin[i];
            lr_data_in  = din[i];
            tick();
            n_vec++;
            if (lr_valid_out !== vin[i] || lr_data_out !== dexp[i]) begin
                n_err++;
                $display("FAIL fwd_%0d got v=%b d=%h want v=%b d=%h",
                         i, lr_valid_out, lr_data_out, vin[i], dexp[i]);
            end
        end
        idle();
        n_vec++;
        if (lr_h_count !== 5'd3) begin
            n_err++;
            $display("FAIL fwd_count got %0d want 3", lr_h_count);
        end
        lr_h_flush = 1'b1;
        tick();
        lr_h_flush = 1'b0;
        n_vec++;
        if (lr_h_count !== 5'd0 || lr_h_empty !== 1'b1) begin
            n_err++;
            $display("FAIL fwd_flush got cnt=%0d e=%b want cnt=0 e=1",
                     lr_h_count, lr_h_empty);
        end
    endtask

    task automatic test_fifo_order();
        logic [15:0] vals [3];
        vals = '{16'h0100, 16'hFF00, 16'h0300};
        for (int i = 0; i < 3; i++) begin
            lr_valid_in = 1'b1;
            lr_data_in  = vals[i];
            tick();
        end
        idle();
        for (int i = 0; i < 3; i++) begin
            lr_h_rd_en = 1'b1;
            tick();
            n_vec++;
            if (lr_d_H_valid_out !== 1'b1 || lr_d_H_data_out !== vals[i]) begin
                n_err++;
                $display("FAIL order_%0d got v=%b d=%h want v=1 d=%h",
                         i, lr_d_H_valid_out, lr_d_H_data_out, vals[i]);
            end
        end
        idle();
        tick();
        n_vec++;
        if (lr_h_empty !== 1'b1 || lr_h_count !== 5'd0 || lr_d_H_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL order_end got e=%b cnt=%0d v=%b want e=1 cnt=0 v=0",
                     lr_h_empty, lr_h_count, lr_d_H_valid_out);
        end
    endtask

    task automatic test_overflow();
        for (int i = 0; i < 16; i++) begin
            lr_valid_in = 1'b1;
            lr_data_in  = 16'h1000 + 16'(i);
            tick();
        end
        n_vec++;
        if (lr_h_full !== 1'b1 || lr_h_count !== 5'd16) begin
            n_err++;
            $display("FAIL full got f=%b cnt=%0d want f=1 cnt=16",
                     lr_h_full, lr_h_count);
        end
        lr_data_in = 16'h7777;
        tick();
        idle();
        n_vec++;
        if (lr_valid_out !== 1'b1 || lr_data_out !== 16'h7777 || lr_h_count !== 5'd16) begin
            n_err++;
            $display("FAIL ovf_write got v=%b d=%h cnt=%0d want v=1 d=7777 cnt=16",
                     lr_valid_out, lr_data_out, lr_h_count);
        end
`ifdef LR_H_CACHE_ERR_EN
        n_vec++;
        if (lr_h_err !== 2'b01) begin
            n_err++;
            $display("FAIL ovf_err got %b want 01", lr_h_err);
        end
`endif
        for (int i = 0; i < 16; i++) begin
            lr_h_rd_en = 1'b1;
            tick();
            n_vec++;
            if (lr_d_H_valid_out !== 1'b1 || lr_d_H_data_out !== 16'h1000 + 16'(i)) begin
                n_err++;
                $display("FAIL ovf_replay_%0d got v=%b d=%h want v=1 d=%h",
                         i, lr_d_H_valid_out, lr_d_H_data_out, 16'h1000 + 16'(i));
            end
        end
        idle();
        n_vec++;
        if (lr_h_empty !== 1'b1 || lr_h_count !== 5'd0) begin
            n_err++;
            $display("FAIL ovf_drain got e=%b cnt=%0d want e=1 cnt=0",
                     lr_h_empty, lr_h_count);
        end
    endtask

    task automatic test_underflow();
        lr_h_rd_en = 1'b1;
        tick();
        idle();
        n_vec++;
        if (lr_d_H_valid_out !== 1'b0 || lr_d_H_data_out !== 16'h0000 || lr_h_count !== 5'd0) begin
            n_err++;
            $display("FAIL udf got v=%b d=%h cnt=%0d want v=0 d=0000 cnt=0",
                     lr_d_H_valid_out, lr_d_H_data_out, lr_h_count);
        end
`ifdef LR_H_CACHE_ERR_EN
        n_vec++;
        if (lr_h_err !== 2'b11) begin
            n_err++;
            $display("FAIL udf_err got %b want 11", lr_h_err);
        end
`endif
    endtask

    task automatic test_back_to_back();
        logic [15:0] q [$];
        logic [15:0] exp_d;
        logic        w;
        logic        r;
        for (int k = 0; k < 5; k++) begin
            lr_valid_in = 1'b1;
            lr_data_in  = 16'h2000 + 16'(k);
            q.push_back(lr_data_in);
            tick();
        end
        for (int i = 0; i < 40; i++) begin
            w = (i % 4 != 2);
            r = (i % 4 != 1);
            lr_valid_in = w;
            lr_data_in  = 16'h3000 + 16'(i);
            lr_h_rd_en  = r;
            exp_d = r ? q.pop_front() : 16'h0000;
            if (w)
                q.push_back(lr_data_in);
            tick();
            n_vec++;
            if (lr_d_H_valid_out !== r || lr_d_H_data_out !== exp_d) begin
                n_err++;
                $display("FAIL b2b_%0d got v=%b d=%h want v=%b d=%h",
                         i, lr_d_H_valid_out, lr_d_H_data_out, r, exp_d);
            end
            if (i == 0) begin
                n_vec++;
                if (lr_h_count !== 5'd5) begin
                    n_err++;
                    $display("FAIL b2b_rw_count got %0d want 5", lr_h_count);
                end
            end
        end
        idle();
        n_vec++;
        if (lr_h_count !== 5'd5) begin
            n_err++;
            $display("FAIL b2b_end_count got %0d want 5", lr_h_count);
        end
    endtask

    task automatic test_flush();
        lr_valid_in = 1'b1;
        lr_data_in  = 16'h0444;
        tick();
        tick();
        idle();
        n_vec++;
        if (lr_h_count !== 5'd7) begin
            n_err++;
            $display("FAIL flush_pre got %0d want 7", lr_h_count);
        end
        lr_valid_in = 1'b1;
        lr_data_in  = 16'hFC00;
        lr_h_rd_en  = 1'b1;
        lr_h_flush  = 1'b1;
        tick();
        idle();
        n_vec++;
        if (lr_h_count !== 5'd0 || lr_h_empty !== 1'b1 || lr_d_H_valid_out !== 1'b0) begin
            n_err++;
            $display("FAIL flush_buf got cnt=%0d e=%b v=%b want cnt=0 e=1 v=0",
                     lr_h_count, lr_h_empty, lr_d_H_valid_out);
        end
        n_vec++;
        if (lr_valid_out !== 1'b1 || lr_data_out !== 16'hFE00) begin
            n_err++;
            $display("FAIL flush_fwd got v=%b d=%h want v=1 d=fe00",
                     lr_valid_out, lr_data_out);
        end
`ifdef LR_H_CACHE_ERR_EN
        n_vec++;
        if (lr_h_err !== 2'b11) begin
            n_err++;
            $display("FAIL flush_err got %b want 11", lr_h_err);
        end
`endif
    endtask

    task automatic test_async_reset();
        lr_valid_in = 1'b1;
        lr_data_in  = 16'h0500;
        tick();
        lr_data_in  = 16'h0600;
        lr_h_rd_en  = 1'b1;
        tick();
        n_vec++;
        if (lr_valid_out !== 1'b1 || lr_d_H_valid_out !== 1'b1 || lr_d_H_data_out !== 16'h0500) begin
            n_err++;
            $display("FAIL arst_pre got v=%b hv=%b hd=%h want v=1 hv=1 hd=0500",
                     lr_valid_out, lr_d_H_valid_out, lr_d_H_data_out);
        end
        #3;
        rst = 1'b1;
        #1;
        n_vec++;
        if (lr_valid_out !== 1'b0 || lr_data_out !== 16'h0000 ||
            lr_d_H_valid_out !== 1'b0 || lr_d_H_data_out !== 16'h0000) begin
            n_err++;
            $display("FAIL arst_out got v=%b d=%h hv=%b hd=%h want all 0",
                     lr_valid_out, lr_data_out, lr_d_H_valid_out, lr_d_H_data_out);
        end
        n_vec++;
        if (lr_h_count !== 5'd0 || lr_h_empty !== 1'b1 || lr_h_full !== 1'b0) begin
            n_err++;
            $display("FAIL arst_flags got cnt=%0d e=%b f=%b want cnt=0 e=1 f=0",
                     lr_h_count, lr_h_empty, lr_h_full);
        end
`ifdef LR_H_CACHE_ERR_EN
        n_vec++;
        if (lr_h_err !== 2'b00) begin
            n_err++;
            $display("FAIL arst_err got %b want 00", lr_h_err);
        end
`endif
        idle();
        #1;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_forward();
        test_fifo_order();
        test_overflow();
        test_underflow();
        test_back_to_back();
        test_flush();
        test_async_reset();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/leaky_relu_h_cache.md
# leaky_relu_h_cache

Forward-pass leaky ReLU stage that also caches pre-activation values (H) for the backward pass. It produces the registered activation `lr_data_out` from each valid input and pushes that input into an in-order H buffer. During backprop, the buffer replays the stored H values on request, so `leaky_relu_derivative_child` receives its `lr_d_H_data_in` operand aligned with incoming gradients. It sits between the systolic-array output and the next layer, with its replay port feeding the derivative lane.

## Interface
- `DEPTH`, default 16: H buffer entries; must be a power of two, at least 2.
- `AW`, default `$clog2(DEPTH)`: pointer width; do not override.
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-high.
- `lr_valid_in` input 1: forward sample valid.
- `lr_data_in` input signed 16: pre-activation H, Q8.8.
- `lr_leak_factor_in` input signed 16: leak slope, Q8.8, sampled with each valid input.
- `lr_valid_out` output 1: registered forward valid.
- `lr_data_out` output signed 16: registered activation, Q8.8.
- `lr_h_rd_en` input 1: replay request, one H value per asserted cycle.
- `lr_h_flush` input 1: synchronous clear of the buffer.
- `lr_d_H_valid_out` output 1: replayed H valid.
- `lr_d_H_data_out` output signed 16: replayed H value.
- `lr_h_count` output AW+1: current number of stored entries.
- `lr_h_full` output 1: high when count equals DEPTH.
- `lr_h_empty` output 1: high when count is 0.
- `lr_h_err` output 2: sticky error flags; bit0 = overflow, bit1 = underflow. Present only with `LR_H_CACHE_ERR_EN`.

## Operation
**Forward path**
- When `lr_valid_in` is high: `lr_data_out` <= `lr_data_in` if `lr_data_in` >= 0, otherwise the `fxp_mul(lr_data_in, lr_leak_factor_in)` result, using the codebase's Q8.8 multiplier unchanged.
- When `lr_valid_in` is low: `lr_data_out` <= 0.
- `lr_valid_out` <= `lr_valid_in`.

**H buffer**
- Circular FIFO with write pointer `wp`, read pointer `rp` (both AW bits, wrap modulo DEPTH) and a count.
- Write: on `lr_valid_in` while not full, store `lr_data_in` at `wp` and increment `wp`.
- Write while full: the sample is dropped from the buffer, but the forward output is still produced. Sets err bit0 if the macro is enabled.
- Read: on `lr_h_rd_en` while not empty, `lr_d_H_data_out` <= `mem[rp]`, `lr_d_H_valid_out` <= 1, and `rp` increments.
- Read while empty: `lr_d_H_valid_out` <= 0 and `lr_d_H_data_out` <= 0. Sets err bit1 if the macro is enabled.
- When there is no read, `lr_d_H_valid_out` <= 0 and `lr_d_H_data_out` <= 0.

**Simultaneous events**
- Read and write in the same cycle, not empty and not full: both happen and count is unchanged.
- Read and write while empty: the write is stored, the read returns invalid, and count becomes 1. There is no bypass.
- Read and write while full: the read is served, the write still counts as an overflow and is dropped, and count becomes DEPTH−1.
- `lr_h_flush` has priority over same-cycle read and write to the buffer. It sets `wp`, `rp` and count to 0 and forces replay valid to 0. The forward path is unaffected.
- `lr_h_flush` does not clear `lr_h_err`.

**Reset**
- `rst` clears to 0: `lr_valid_out`, `lr_data_out`, `lr_d_H_valid_out`, `lr_d_H_data_out`, pointers, count and `lr_h_err`.
- After reset, `lr_h_empty` = 1 and `lr_h_full` = 0.
- Memory contents are not reset.
- Reset asserted mid-stream discards all in-flight and stored data immediately, without waiting for a clock edge.

## Timing
- Forward latency: 1 cycle from `lr_valid_in` to `lr_valid_out` and `lr_data_out`.
- Replay latency: 1 cycle from `lr_h_rd_en` to `lr_d_H_valid_out` and `lr_d_H_data_out`.
- Replay order is strictly first-in first-out with respect to forward writes.
- `lr_h_count`, `lr_h_full` and `lr_h_empty` are registered and reflect the state after the last clock edge.
- Sustained throughput: one write and one read per cycle.
- No backpressure on either path; the consumer must check `lr_h_empty`.

## Configuration
- `LR_H_CACHE_ERR_EN` defined: the `lr_h_err` port exists and its bits are sticky until `rst`.
- Undefined: the port and its logic are removed.
- Data-path behaviour on overflow and underflow is identical in both builds.

## Test plan
- Forward with leak 0x0080 (0.5): input 0x0200 → output 0x0200; input 0xFE00 → output 0xFF00; input 0x0000 → output 0x0000. Each appears 1 cycle later with `lr_valid_out` high.
- Write 0x0100, 0xFF00 and 0x0300, then assert `lr_h_rd_en` for 3 cycles → `lr_d_H_data_out` shows 0x0100, 0xFF00, 0x0300 with valid high. Then `lr_h_empty` = 1 and `lr_h_count` = 0.
- Fill 16 entries: `lr_h_full` = 1. A 17th write → count stays 16, the forward output is still produced, err bit0 = 1, and replay returns the first 16 values only.
- Read while empty → valid 0, data 0, err bit1 = 1. Simultaneous read and write when count is 5 → count stays 5 and in-order replay is preserved across pointer wrap after 40 mixed operations.
- `lr_h_flush` asserted together with a write and a read at count 7 → count becomes 0, replay valid 0, and the forward output is produced. Async `rst` pulsed between clock edges → all outputs read 0 before the next clock edge.
